// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
//
// Purpose:
//   Parametrised CPU register file with configurable width, depth and number
//   of combinational read ports. After reset (or a soft clear) a sequential
//   sweep writes zero into every entry, one entry per clock, and the file
//   reports ready only once the sweep has finished. A per-register busy
//   scoreboard lets decode mark a destination as pending (reserve) until the
//   multi-cycle producer writes it back.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, a write presented this cycle is
//   forwarded combinationally to any read port addressing the same register.
//   When undefined, reads always return the stored value.
//
// Parameters:
//   DATA_W   - width of each register
//   ADDR_W   - address width, DEPTH = 2**ADDR_W entries
//   NUM_RD   - number of combinational read ports
//   ZERO_REG - when 1, entry 0 reads zero, ignores writes and is never busy
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   clr      in   soft-clear request pulse (restarts the zeroing sweep)
//   ready    out  high once the sweep is done and the file is usable
//   we3      in   write enable
//   v_f      in   writeback valid; a write needs we3 & v_f
//   a3       in   write address
//   wd3      in   write data
//   rsv      in   reserve request, marks rsv_addr busy
//   rsv_addr in   register to reserve
//   rd_addr  in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  out  packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy  out  busy bit of each read port's address
// ---------------------------------------------------------------------------
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  output logic                       ready,
  input  logic                       we3,
  input  logic                       v_f,
  input  logic [ADDR_W-1:0]          a3,
  input  logic [DATA_W-1:0]          wd3,
  input  logic                       rsv,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_busy;

  logic                w_ready;
  logic                w_a3_zero;
  logic                w_rsv_zero;
  logic                w_wr_req;
  logic                w_rsv_req;
  logic                w_wr_commit;
  logic                w_rsv_commit;

  assign w_ready = (r_state == ST_READY);
  assign ready   = w_ready;

  // Entry 0 is only special when the zero register is enabled.
  assign w_a3_zero  = (ZERO_REG != 0) && (a3 == '0);
  assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

  // A request is "presented" when the file is usable; it only commits when
  // no soft clear lands on the same edge, because clear discards it.
  assign w_wr_req     = we3 & v_f & w_ready & ~w_a3_zero;
  assign w_rsv_req    = rsv & w_ready & ~w_rsv_zero;
  assign w_wr_commit  = w_wr_req & ~clr;
  assign w_rsv_commit = w_rsv_req & ~clr;

  // Sweep/ready state register. Reset always restarts the sweep at entry 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic. The sweep finishes on the edge that zeroes the last
  // entry; the index is not allowed to wrap past it. A clear request in
  // either state restarts the sweep from entry 0.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_CLEAR: begin
        if (clr) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_READY;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Storage array. It has no reset of its own: the sweep zeroes one entry
  // per clock while in CLEAR, and normal writes only happen in READY.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_commit) begin
      r_mem[a3] <= wd3;
    end
  end

  // Busy scoreboard. A committed write clears the bit and a reserve sets
  // it; the reserve is applied last so that a new producer reserving the
  // same register on the same edge leaves it busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else if (!w_ready || clr) begin
      r_busy <= '0;
    end else begin
      if (w_wr_commit) begin
        r_busy[a3] <= 1'b0;
      end
      if (w_rsv_commit) begin
        r_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  // Read ports. Outputs are held at zero until the sweep is done, and the
  // zero register always reads as zero and never busy.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    logic              w_addr_zero;

    assign w_addr      = rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_addr_zero = (ZERO_REG != 0) && (w_addr == '0);

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_ready && !w_addr_zero) begin
        w_data = r_mem[w_addr];
        w_busy = r_busy[w_addr];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the data being written this cycle; the port only looks busy
      // if a new reserve for the same register arrives alongside the write.
      if (w_wr_req && (a3 == w_addr)) begin
        w_data = wd3;
        w_busy = w_rsv_req && (rsv_addr == w_addr);
      end
`endif
    end

    assign rd_data[gi*DATA_W +: DATA_W] = w_data;
    assign rd_busy[gi]                  = w_busy;
  end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the CPU's 32x32 register file, with width, depth and read-port count all configurable.
- Adds a sequential post-reset/soft-clear sweep that zeroes every entry, and a per-register busy scoreboard for multi-cycle producers such as loads.
- Sits between decode (reads, reserve) and writeback (write).
- Optional write-through bypass.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of combinational read ports.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero (reads 0, writes dropped, never busy).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  soft-clear request pulse.
- ready  output  1  high when the clear sweep is done and the file is usable.
- we3  input  1  write enable.
- v_f  input  1  writeback valid flag; a write needs we3 & v_f.
- a3  input  ADDR_W  write address.
- wd3  input  DATA_W  write data.
- rsv  input  1  reserve request; marks rsv_addr busy.
- rsv_addr  input  ADDR_W  register to reserve.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed read data.
- rd_busy  output  NUM_RD  busy bit of each read address.

Behaviour:
- Reset (reset low, asynchronous):
  - state = CLEAR, sweep index = 0, ready = 0.
  - All busy bits = 0.
  - rd_data = 0 on every port; rd_busy = 0.
  - Array contents are not reset directly; the sweep zeroes them.
- State CLEAR:
  - Each rising edge writes 0 to entry[index] and increments index.
  - On the edge that writes entry DEPTH-1: state becomes READY and ready goes to 1.
  - ready is therefore 1 after exactly DEPTH rising edges following reset release.
  - Write, reserve and clear-of-busy requests are ignored.
  - rd_data is forced to 0 and rd_busy to 0.
- State READY:
  - Write: at a rising edge with we3 & v_f & ready, entry[a3] <= wd3.
  - With ZERO_REG=1 and a3 = 0 the write is dropped.
  - Reads are combinational: rd_data[i] = entry[rd_addr[i]], or 0 for address 0 when ZERO_REG=1.
  - Multiple ports reading the same address all return the same value.
- Scoreboard:
  - A rising edge with rsv & ready sets busy[rsv_addr].
  - A committed write clears busy[a3].
  - Reserve and write to the same address on the same edge: busy ends 1 (the new producer wins); the data still commits.
  - Reserve of address 0 with ZERO_REG=1 is ignored.
  - rd_busy[i] = busy[rd_addr[i]] (combinational).
- Soft clear:
  - clr high at a rising edge in READY: next state CLEAR, index = 0, ready = 0, all busy bits cleared on that edge.
  - Any write or reserve presented on that same edge is discarded.
  - clr during CLEAR restarts the sweep at index 0.
- Reset asserted mid-sweep or mid-operation takes effect immediately and the sweep restarts from 0.
- Index arithmetic is ADDR_W bits wide; the terminal condition is index == DEPTH-1, with no wrap beyond it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we3 & v_f & ready and a3 == rd_addr[i] (nonzero when ZERO_REG=1), rd_data[i] returns wd3 in the same cycle.
  - rd_busy[i] for that port reads 0, unless rsv also targets the same address that cycle, in which case it reads 1.
- Not defined: reads return the stored value, so the new data is visible from the cycle after the write edge; rd_busy reflects only registered state.

Test Plan:
- Release reset, DEPTH=32, then hold rd_addr = 5 -> ready = 0 for 31 edges and 1 after the 32nd; rd_data = 0 throughout; all busy bits 0.
- READY: write a3=7, wd3=0xDEADBEEF, v_f=1; next cycle read port 0 = 7 and port 1 = 7 -> both return 0xDEADBEEF. Repeat with v_f=0, wd3=0x1 -> value unchanged.
- Write a3=0, wd3=0xFFFFFFFF with ZERO_REG=1 -> read of 0 returns 0. rsv_addr=0 -> rd_busy stays 0.
- rsv on 9 -> rd_busy=1 next cycle. Same-edge rsv=9 and write a3=9, wd3=0x55 -> busy stays 1, data 0x55. Later write 9 alone -> busy 0.
- Pulse clr after writing reg 3 = 0xA5 -> ready falls for 32 edges; reg 3 reads 0 afterward; a write presented on the clr edge is lost. Assert reset at sweep index 12 -> sweep restarts and takes the full 32 edges.
- REGFILE_BYPASS_EN defined: write a3=4, wd3=0x1234 while rd_addr port 0 = 4 -> rd_data port 0 = 0x1234 in the same cycle. Without the macro -> old value that cycle, 0x1234 the next.
